// File: rtl/rect_pkg.sv
// Shared types for the rectangle scheduler: colour codes, slot descriptor,
// the miss descriptor that makes genRect draw black, and FSM states.
package rect_pkg;

  localparam int RECT_CW = 10;

  typedef enum logic [1:0] {
    WHITE = 2'd0,
    RED   = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_t;

  typedef struct packed {
    logic               en;
    logic [RECT_CW-1:0] x1;
    logic [RECT_CW-1:0] y1;
    logic [RECT_CW-1:0] x2;
    logic [RECT_CW-1:0] y2;
    color_t             color;
  } rect_t;

  // x1/y1 all-ones with x2/y2 zero is an empty box, so genRect outputs black
  localparam rect_t MISS_RECT = '{
    en:    1'b0,
    x1:    {RECT_CW{1'b1}},
    y1:    {RECT_CW{1'b1}},
    x2:    {RECT_CW{1'b0}},
    y2:    {RECT_CW{1'b0}},
    color: WHITE
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic rect_hit(input rect_t r,
                                    input logic [RECT_CW-1:0] px,
                                    input logic [RECT_CW-1:0] py);
    return r.en && (px >= r.x1) && (px <= r.x2) && (py >= r.y1) && (py <= r.y2);
  endfunction

endpackage

// File: rtl/rect_prio_enc.sv
// Lowest-index-wins priority encoder; idx is zero when nothing requests.
module rect_prio_enc #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          hit,
  output logic [IW-1:0] idx
);

  always_comb begin
    hit = |req;
    idx = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = req[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/rect_list_ctrl.sv
// Shadow/active rectangle table with frame-start commit and a 2-stage
// per-pixel lookup that feeds the single genRect colour stage.
import rect_pkg::*;

module rect_list_ctrl #(
  parameter int N_RECT  = 8,
  parameter int COORD_W = RECT_CW,
  localparam int IDX_W  = $clog2(N_RECT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x1,
  input  logic [COORD_W-1:0] wr_y1,
  input  logic [COORD_W-1:0] wr_x2,
  input  logic [COORD_W-1:0] wr_y2,
  input  logic [1:0]         wr_color,
  input  logic               clr_req,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               sel_valid,
  output logic [IDX_W-1:0]   sel_idx,
  output logic [COORD_W-1:0] sel_x1,
  output logic [COORD_W-1:0] sel_y1,
  output logic [COORD_W-1:0] sel_x2,
  output logic [COORD_W-1:0] sel_y2,
  output logic [1:0]         sel_color,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               wr_ready_q, wr_ready_d;
  logic               busy_q, busy_d;
  logic               wr_acc_s;

  rect_t              shadow_q [N_RECT];
  rect_t              shadow_d [N_RECT];
  rect_t              active_q [N_RECT];

  logic [N_RECT-1:0]  hit_d, hit_q;
  logic [COORD_W-1:0] px_q, py_q;
  logic               pv_q;

  logic               win_hit_s;
  logic [IDX_W-1:0]   win_idx_s;
  rect_t              sel_rect_q, sel_rect_d;
  logic               sel_valid_q;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [COORD_W-1:0] out_x_q, out_y_q;

  assign wr_acc_s = wr_valid & wr_ready_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wr_ready_d = wr_ready_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_cnt_d  = {IDX_W{1'b0}};
          wr_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          wr_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == IDX_W'(N_RECT - 1)) begin
          state_d    = ST_IDLE;
          wr_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          clr_cnt_d  = clr_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wr_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= {IDX_W{1'b0}};
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
    end
  end

  // A write and the clear sweep never coincide: writes are only taken in IDLE.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_acc_s) begin
      shadow_d[wr_idx] = '{en: wr_en, x1: wr_x1, y1: wr_y1, x2: wr_x2, y2: wr_y2,
                           color: color_t'(wr_color)};
    end else if (state_q == ST_CLEAR) begin
      shadow_d[clr_cnt_q].en = 1'b0;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Commit copies the pre-edge shadow, so a same-cycle write waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_RECT; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= frame_start ? shadow_q[i] : active_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_RECT; i++) begin
      hit_d[i] = rect_hit(active_q[i], x, y);
    end
  end

  rect_prio_enc #(.N(N_RECT)) u_prio (
    .req (hit_q & {N_RECT{pv_q}}),
    .hit (win_hit_s),
    .idx (win_idx_s)
  );

  always_comb begin
    if (win_hit_s) begin
      sel_rect_d = active_q[win_idx_s];
      sel_idx_d  = win_idx_s;
    end else begin
      sel_rect_d = MISS_RECT;
      sel_idx_d  = {IDX_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= {N_RECT{1'b0}};
      px_q        <= {COORD_W{1'b0}};
      py_q        <= {COORD_W{1'b0}};
      pv_q        <= 1'b0;
      sel_rect_q  <= MISS_RECT;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= {IDX_W{1'b0}};
      out_x_q     <= {COORD_W{1'b0}};
      out_y_q     <= {COORD_W{1'b0}};
    end else begin
      hit_q       <= hit_d;
      px_q        <= x;
      py_q        <= y;
      pv_q        <= pix_valid;
      sel_rect_q  <= sel_rect_d;
      sel_valid_q <= win_hit_s;
      sel_idx_q   <= sel_idx_d;
      out_x_q     <= px_q;
      out_y_q     <= py_q;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign sel_valid = sel_valid_q;
  assign sel_idx   = sel_idx_q;
  assign sel_x1    = sel_rect_q.x1;
  assign sel_y1    = sel_rect_q.y1;
  assign sel_x2    = sel_rect_q.x2;
  assign sel_y2    = sel_rect_q.y2;
  assign sel_color = sel_rect_q.color;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_rect_list_ctrl.sv
// Self-checking bench for rect_list_ctrl: table of pixels with expected
// selections, scoreboarded against the 2-cycle pipeline, plus clear/reset sequences.
module tb_rect_list_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready, wr_en, clr_req, frame_start, pix_valid, busy;
  logic [2:0] wr_idx, sel_idx;
  logic [9:0] wr_x1, wr_y1, wr_x2, wr_y2, x, y;
  logic [9:0] sel_x1, sel_y1, sel_x2, sel_y2, out_x, out_y;
  logic [1:0] wr_color, sel_color;
  logic       sel_valid;

  rect_list_ctrl #(.N_RECT(8), .COORD_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_en(wr_en), .wr_x1(wr_x1), .wr_y1(wr_y1),
    .wr_x2(wr_x2), .wr_y2(wr_y2), .wr_color(wr_color), .clr_req(clr_req),
    .frame_start(frame_start), .pix_valid(pix_valid), .x(x), .y(y),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_x1(sel_x1), .sel_y1(sel_y1),
    .sel_x2(sel_x2), .sel_y2(sel_y2), .sel_color(sel_color),
    .out_x(out_x), .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [9:0] x, y;
    logic       ev;
    logic [2:0] ei;
    logic [9:0] ex1, ey1, ex2, ey2;
    logic [1:0] ec;
  } vec_t;

  typedef struct {
    int due;
    int id;
  } sb_t;

  vec_t vt [24];
  sb_t  sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t vh(input int px, input int py, input int idx,
                              input int a, input int b, input int c, input int d,
                              input int col);
    vec_t v;
    v.pv = 1'b1; v.x = 10'(px); v.y = 10'(py);
    v.ev = 1'b1; v.ei = 3'(idx);
    v.ex1 = 10'(a); v.ey1 = 10'(b); v.ex2 = 10'(c); v.ey2 = 10'(d);
    v.ec = 2'(col);
    return v;
  endfunction

  function automatic vec_t vm(input logic pv, input int px, input int py);
    vec_t v;
    v.pv = pv; v.x = 10'(px); v.y = 10'(py);
    v.ev = 1'b0; v.ei = 3'd0;
    v.ex1 = 10'h3FF; v.ey1 = 10'h3FF; v.ex2 = 10'd0; v.ey2 = 10'd0;
    v.ec = 2'd0;
    return v;
  endfunction

  function automatic logic [65:0] act_pack();
    return {sel_valid, sel_idx, sel_x1, sel_y1, sel_x2, sel_y2, sel_color, out_x, out_y};
  endfunction

  task automatic chk(input string nm, input int tag, input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s%0d actual=%h required=%h", nm, tag, act, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("pix", e.id, {2'b00, act_pack()},
          {2'b00, vt[e.id].ev, vt[e.id].ei, vt[e.id].ex1, vt[e.id].ey1,
           vt[e.id].ex2, vt[e.id].ey2, vt[e.id].ec, vt[e.id].x, vt[e.id].y});
    end
  endtask

  task automatic set_wr(input int i, input int a, input int b, input int c,
                        input int d, input int col);
    wr_valid = 1'b1; wr_idx = 3'(i); wr_en = 1'b1;
    wr_x1 = 10'(a); wr_y1 = 10'(b); wr_x2 = 10'(c); wr_y2 = 10'(d);
    wr_color = 2'(col);
  endtask

  task automatic wr(input int i, input int a, input int b, input int c,
                    input int d, input int col);
    set_wr(i, a, b, c, d, col);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pix_valid = vt[i].pv; x = vt[i].x; y = vt[i].y;
      sb.push_back('{due: cyc + 2, id: i});
      tick();
    end
    pix_valid = 1'b0;
    tick();
    tick();
  endtask

  // wr_ready, busy and every sel/out bit after a reset
  task automatic chk_reset_state(input int tag);
    chk("reset_state", tag, {wr_ready, busy, act_pack()},
        {1'b1, 1'b0, 1'b0, 3'd0, 10'h3FF, 10'h3FF, 10'd0, 10'd0, 2'd0, 10'd0, 10'd0});
  endtask

  initial begin
    vt[0]  = vh(15, 15, 0, 10, 10, 20, 20, 1);
    vt[1]  = vm(1'b1, 21, 15);
    vt[2]  = vh(55, 55, 1, 50, 50, 60, 60, 3);
    vt[3]  = vh(5, 5, 3, 0, 0, 100, 100, 2);
    vt[4]  = vh(15, 15, 0, 10, 10, 20, 20, 1);
    vt[5]  = vh(15, 15, 0, 10, 10, 20, 20, 1);
    vt[6]  = vh(15, 15, 0, 10, 10, 20, 20, 0);
    vt[7]  = vh(15, 15, 0, 10, 10, 20, 20, 0);
    vt[8]  = vh(15, 15, 0, 10, 10, 20, 20, 1);
    vt[9]  = vm(1'b1, 0, 0);
    vt[10] = vm(1'b1, 1023, 1023);
    vt[11] = vm(1'b1, 500, 500);
    vt[12] = vh(100, 200, 5, 100, 200, 300, 400, 3);
    vt[13] = vh(300, 400, 5, 100, 200, 300, 400, 3);
    vt[14] = vm(1'b1, 301, 400);
    vt[15] = vm(1'b1, 100, 199);
    vt[16] = vm(1'b1, 25, 5);
    vt[17] = vm(1'b1, 30, 0);
    vt[18] = vm(1'b0, 150, 300);
    vt[19] = vh(1023, 1023, 7, 0, 0, 1023, 1023, 0);
    vt[20] = vh(150, 300, 5, 100, 200, 300, 400, 3);
    vt[21] = vh(25, 5, 7, 0, 0, 1023, 1023, 0);
    vt[22] = vm(1'b1, 1023, 1023);
    vt[23] = vm(1'b1, 150, 300);

    rst_n = 1'b0; wr_valid = 1'b0; wr_idx = 3'd0; wr_en = 1'b0;
    wr_x1 = 10'd0; wr_y1 = 10'd0; wr_x2 = 10'd0; wr_y2 = 10'd0; wr_color = 2'd0;
    clr_req = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; x = 10'd0; y = 10'd0;
    tick();
    tick();
    chk_reset_state(0);
    rst_n = 1'b1;
    tick();
    chk_reset_state(1);

    // basic hit and miss
    wr(0, 10, 10, 20, 20, 1);
    commit();
    run(0, 1);

    // priority: lower slot wins inside the overlap
    wr(3, 0, 0, 100, 100, 2);
    wr(1, 50, 50, 60, 60, 3);
    commit();
    run(2, 4);

    // shadowing, including a write landing in the commit cycle
    wr(0, 10, 10, 20, 20, 0);
    run(5, 5);
    commit();
    run(6, 6);
    set_wr(0, 10, 10, 20, 20, 1);
    frame_start = 1'b1;
    tick();
    wr_valid = 1'b0; frame_start = 1'b0;
    run(7, 7);
    commit();
    run(8, 8);

    // clear: 8 busy cycles, no writes accepted, clr_req held throughout
    for (int i = 0; i < 8; i++) wr(i, 0, 0, 1023, 1023, i % 4);
    clr_req = 1'b1;
    tick();
    set_wr(5, 0, 0, 1023, 1023, 2);
    for (int k = 0; k < 8; k++) begin
      chk("clear_busy", k, {66'd0, busy, wr_ready}, {66'd0, 1'b1, 1'b0});
      tick();
    end
    chk("clear_done", 0, {66'd0, busy, wr_ready}, {66'd0, 1'b0, 1'b1});
    clr_req = 1'b0; wr_valid = 1'b0;
    commit();
    run(9, 11);

    // boundaries
    wr(2, 30, 0, 20, 10, 1);
    wr(5, 100, 200, 300, 400, 3);
    commit();
    run(12, 18);
    wr(7, 0, 0, 1023, 1023, 0);
    commit();
    run(19, 21);

    // asynchronous reset in the third clear cycle
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_state(2);
    tick();
    rst_n = 1'b1;
    tick();
    commit();
    run(22, 23);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_list_ctrl.md
# rect_list_ctrl

Rectangle scheduler that shares a single `genRect` colour stage among up to `N_RECT` on-screen rectangles in the Connect4 VGA path. The game logic writes rectangle descriptors into a shadow table through a valid/ready port. The shadow table is committed to the active table only at frame start, which prevents tearing. For every pixel, a 2-stage pipeline selects the highest-priority active rectangle covering that pixel and drives its coordinates and colour, together with the delayed pixel position, into `genRect`.

## Interface
- `N_RECT`, 8, number of rectangle slots; power of two, 2..16.
- `COORD_W`, 10, coordinate width.
- `IDX_W`, $clog2(N_RECT), slot index width (derived).

- `clk` in 1 pixel clock.
- `rst_n` in 1 asynchronous, active-low reset.
- `wr_valid` in 1 descriptor write request.
- `wr_ready` out 1 write accepted when `wr_valid && wr_ready`.
- `wr_idx` in IDX_W target slot.
- `wr_en` in 1 slot-enable bit written with the descriptor.
- `wr_x1`, `wr_y1`, `wr_x2`, `wr_y2` in COORD_W each; inclusive bounds.
- `wr_color` in 2 colour code: 0 white, 1 red, 2 blue, 3 green.
- `clr_req` in 1 pulse; disables all shadow slots.
- `frame_start` in 1 one-cycle pulse from VGA timing; commit point.
- `pix_valid`, `x`, `y` in 1/COORD_W/COORD_W current pixel.
- `sel_valid` out 1 a rectangle covers the delayed pixel.
- `sel_idx` out IDX_W winning slot.
- `sel_x1`, `sel_y1`, `sel_x2`, `sel_y2` out COORD_W to `genRect`.
- `sel_color` out 2 to `genRect`.
- `out_x`, `out_y` out COORD_W pixel delayed to align with `sel_*`.
- `busy` out 1 clear in progress.

## Operation
- **FSM states:** IDLE and CLEAR. Reset state is IDLE.
- **IDLE:** `wr_ready`=1.
  - An accepted write stores {en, x1, y1, x2, y2, color} into `shadow[wr_idx]` at the clock edge.
  - `clr_req` moves the FSM to CLEAR and loads the clear counter to 0. If a write is also accepted in that cycle, the write is applied first and is then cleared.
- **CLEAR:** `wr_ready`=0 and `busy`=1.
  - One slot's `en` is cleared per cycle, in slot order 0..N_RECT-1.
  - After the last slot, the FSM returns to IDLE. Duration is exactly N_RECT cycles.
  - `clr_req` is ignored while in CLEAR.
- **Commit:** on a `frame_start` cycle, `active <= shadow` with all slots updated in parallel, regardless of FSM state.
  - A write accepted in the same cycle lands in shadow only and becomes visible at the next commit.
  - A commit during CLEAR copies the partially cleared table.
- **Hit test, per slot:** `en && x>=x1 && x<=x2 && y>=y1 && y<=y2`, unsigned compare with inclusive bounds.
  - A slot with x1>x2 or y1>y2 never hits.
- **Priority:** the lowest slot index wins.
- **Miss, or `pix_valid`=0 in the launching cycle:**
  - `sel_valid`=0, `sel_idx`=0.
  - `sel_x1`=`sel_y1`=all-ones, `sel_x2`=`sel_y2`=0, so `genRect` outputs black.
  - `sel_color`=0.
- **Reset values:**
  - Shadow and active tables are all-zero, so every slot is disabled.
  - `wr_ready`=1, `busy`=0.
  - All `sel_*` outputs hold the miss values.
  - `out_x`=`out_y`=0.

## Timing
- **Stage 1:** registers the per-slot hit vector against the active table, plus `x`, `y` and `pix_valid`.
- **Stage 2:** registers the priority-encoded winner's descriptor, `sel_valid`/`sel_idx` and `out_x`/`out_y`.
- **Latency:** a pixel presented at cycle t appears on `sel_*`/`out_*` at t+2. Throughput is one pixel per cycle.
- **Commit visibility:** the active table changes at the edge ending the `frame_start` cycle. A pixel presented in the cycle after `frame_start` uses the new table.
- **Asynchronous reset mid-operation:**
  - Returns the FSM to IDLE and clears both tables and the pipeline immediately.
  - An in-flight clear or an uncommitted write is lost.
- **Write throughput:** one write per cycle in IDLE. Back-to-back writes to the same slot resolve as last-write-wins.

## Structure
- Package `rect_pkg`:
  - `color_t` enum with WHITE/RED/BLUE/GREEN = 0..3.
  - `rect_t` packed struct {en, x1, y1, x2, y2, color}.
  - `MISS_RECT` constant.
  - FSM state enum.
- Sub-module `rect_prio_enc`: parameterised N_RECT-input lowest-index priority encoder that outputs {hit, idx}.
- `genRect` stays outside. The top level instantiates `rect_list_ctrl` followed by `genRect`.

## Test plan
- **Reset and basic hit:** after reset, write slot 0 = (10,10,20,20, RED) with en=1, pulse `frame_start`, then present (15,15).
  - Two cycles later, require `sel_valid`=1, `sel_idx`=0, coordinates 10/10/20/20 and colour 1.
  - Pixel (21,15) must give the miss outputs.
- **Priority:** slot 3 = (0,0,100,100, BLUE) and slot 1 = (50,50,60,60, GREEN), then commit.
  - (55,55) must give `sel_idx`=1, colour 3.
  - (5,5) must give `sel_idx`=3, colour 2.
- **Shadowing:** after a committed slot 0 rectangle, rewrite slot 0 to colour WHITE without a commit.
  - Pixels must still show RED.
  - After `frame_start`, pixels must show WHITE.
  - A write in the same cycle as `frame_start` must appear only after the following commit.
- **Clear:** fill 8 slots, assert `clr_req`.
  - Require `wr_ready`=0 and `busy`=1 for exactly 8 cycles, with writes not accepted.
  - After a commit, every pixel must miss.
- **Boundaries:**
  - Bounds are inclusive: (x1,y1) and (x2,y2) hit.
  - The degenerate rectangle (30,0,20,10) never hits.
  - A full-screen rectangle (0,0,1023,1023) hits (1023,1023).
  - With `pix_valid`=0, the outputs are the miss values.
- **Reset mid-clear:** deassert `rst_n` during CLEAR cycle 3.
  - Require `busy`=0 and `wr_ready`=1 immediately.
  - Tables must be empty and `sel_*` must hold the miss values.
